// File: rtl/contador_display_pkg.sv
// Shared types and constants for the event-count display driver:
// FSM encodings, active-low segment/anode patterns and the double-dabble step.
package contador_display_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  localparam logic [6:0] SEG_BLANK = 7'b1111111;
  localparam logic [6:0] SEG_0     = 7'b1000000;
  localparam logic [6:0] SEG_1     = 7'b1111001;
  localparam logic [6:0] SEG_2     = 7'b0100100;
  localparam logic [6:0] SEG_3     = 7'b0110000;
  localparam logic [6:0] SEG_4     = 7'b0011001;
  localparam logic [6:0] SEG_5     = 7'b0010010;
  localparam logic [6:0] SEG_6     = 7'b0000010;
  localparam logic [6:0] SEG_7     = 7'b1111000;
  localparam logic [6:0] SEG_8     = 7'b0000000;
  localparam logic [6:0] SEG_9     = 7'b0010000;

  localparam logic [3:0] AN_OFF    = 4'b1111;

  // One double-dabble iteration: add 3 to every BCD nibble >= 5, then shift left.
  function automatic logic [19:0] dd_step(input logic [19:0] v);
    logic [19:0] r;
    r = v;
    for (int i = 2; i < 5; i++) begin
      if (r[i*4 +: 4] >= 4'd5) begin
        r[i*4 +: 4] = r[i*4 +: 4] + 4'd3;
      end
    end
    return {r[18:0], 1'b0};
  endfunction

endpackage

// File: rtl/contador_display_if.sv
// Count input and display outputs of contador_display bundled as one port.
interface contador_display_if;
  logic [7:0] count_in;
  logic [3:0] an;
  logic [6:0] seg;
  logic       busy;

  modport master (output count_in, input an, input seg, input busy);
  modport slave  (input count_in, output an, output seg, output busy);
endinterface

// File: rtl/contador_display_bcd_to_seg7.sv
// Combinational BCD digit to active-low {g,f,e,d,c,b,a} segment decoder.
module bcd_to_seg7
  import contador_display_pkg::*;
(
  input  logic [3:0] bcd,
  output logic [6:0] seg
);

  always_comb begin
    case (bcd)
      4'd0:    seg = SEG_0;
      4'd1:    seg = SEG_1;
      4'd2:    seg = SEG_2;
      4'd3:    seg = SEG_3;
      4'd4:    seg = SEG_4;
      4'd5:    seg = SEG_5;
      4'd6:    seg = SEG_6;
      4'd7:    seg = SEG_7;
      4'd8:    seg = SEG_8;
      4'd9:    seg = SEG_9;
      default: seg = SEG_BLANK;
    endcase
  end

endmodule

// File: rtl/contador_display.sv
// Converts the 8-bit event count to BCD (sequential double-dabble) and scans it
// onto a 4-slot common-anode 7-segment display. Optional macro: LEADING_ZERO_BLANK_EN.
module contador_display
  import contador_display_pkg::*;
#(
  parameter int REFRESH_DIV = 50000
) (
  input  logic               clk,
  input  logic               rst,
  contador_display_if.slave  bus
);

  localparam int CW = (REFRESH_DIV > 2) ? $clog2(REFRESH_DIV) : 1;
  localparam logic [CW-1:0] REF_MAX = CW'(REFRESH_DIV - 1);

  state_t        state_q, state_d;
  logic [7:0]    snap_q, snap_d;
  logic [19:0]   sr_q, sr_d;
  logic [3:0]    iter_q, iter_d;
  logic [3:0]    disp_h_q, disp_h_d;
  logic [3:0]    disp_t_q, disp_t_d;
  logic [3:0]    disp_u_q, disp_u_d;
  logic          busy_q, busy_d;
  logic [CW-1:0] refcnt_q, refcnt_d;
  logic [1:0]    slot_q, slot_d;
  logic [3:0]    an_q, an_d;
  logic [6:0]    seg_q, seg_d;

  logic [3:0]    digit_mux;
  logic [6:0]    digit_seg;
  logic          blank_h;
  logic          blank_t;

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      snap_q   <= '0;
      sr_q     <= '0;
      iter_q   <= '0;
      disp_h_q <= '0;
      disp_t_q <= '0;
      disp_u_q <= '0;
      busy_q   <= 1'b0;
      refcnt_q <= '0;
      slot_q   <= '0;
      an_q     <= AN_OFF;
      seg_q    <= SEG_BLANK;
    end else begin
      state_q  <= state_d;
      snap_q   <= snap_d;
      sr_q     <= sr_d;
      iter_q   <= iter_d;
      disp_h_q <= disp_h_d;
      disp_t_q <= disp_t_d;
      disp_u_q <= disp_u_d;
      busy_q   <= busy_d;
      refcnt_q <= refcnt_d;
      slot_q   <= slot_d;
      an_q     <= an_d;
      seg_q    <= seg_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (bus.count_in != snap_q) state_d = SHIFT;
      SHIFT:   if (iter_q == 4'd7) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Conversion datapath
  always_comb begin
    snap_d   = snap_q;
    sr_d     = sr_q;
    iter_d   = iter_q;
    disp_h_d = disp_h_q;
    disp_t_d = disp_t_q;
    disp_u_d = disp_u_q;
    busy_d   = busy_q;
    case (state_q)
      IDLE: begin
        if (bus.count_in != snap_q) begin
          snap_d = bus.count_in;
          sr_d   = {12'd0, bus.count_in};
          iter_d = 4'd0;
          busy_d = 1'b1;
        end
      end
      SHIFT: begin
        sr_d   = dd_step(sr_q);
        iter_d = iter_q + 4'd1;
      end
      DONE: begin
        disp_h_d = sr_q[19:16];
        disp_t_d = sr_q[15:12];
        disp_u_d = sr_q[11:8];
        busy_d   = 1'b0;
      end
      default: busy_d = 1'b0;
    endcase
  end

`ifdef LEADING_ZERO_BLANK_EN
  assign blank_h = (disp_h_q == 4'd0);
  assign blank_t = blank_h && (disp_t_q == 4'd0);
`else
  assign blank_h = 1'b0;
  assign blank_t = 1'b0;
`endif

  always_comb begin
    case (slot_q)
      2'd0:    digit_mux = disp_u_q;
      2'd1:    digit_mux = disp_t_q;
      2'd2:    digit_mux = disp_h_q;
      default: digit_mux = 4'd0;
    endcase
  end

  bcd_to_seg7 u_dec (
    .bcd (digit_mux),
    .seg (digit_seg)
  );

  // Scan counter and registered display outputs
  always_comb begin
    refcnt_d = refcnt_q + 1'b1;
    slot_d   = slot_q;
    if (refcnt_q == REF_MAX) begin
      refcnt_d = '0;
      slot_d   = slot_q + 2'd1;
    end
    an_d  = AN_OFF;
    seg_d = SEG_BLANK;
    case (slot_q)
      2'd0: begin
        an_d  = 4'b1110;
        seg_d = digit_seg;
      end
      2'd1: begin
        an_d  = 4'b1101;
        seg_d = blank_t ? SEG_BLANK : digit_seg;
      end
      2'd2: begin
        an_d  = 4'b1011;
        seg_d = blank_h ? SEG_BLANK : digit_seg;
      end
      default: begin
        an_d  = AN_OFF;
        seg_d = SEG_BLANK;
      end
    endcase
  end

  assign bus.an   = an_q;
  assign bus.seg  = seg_q;
  assign bus.busy = busy_q;

endmodule

// File: tb/tb_contador_display.sv
// Directed bench for contador_display with an arithmetic reference model checked
// every cycle plus literal frame/latency checks. Honours LEADING_ZERO_BLANK_EN.
module tb_contador_display;

  localparam int DIV = 4;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  contador_display_if bus();

  contador_display #(.REFRESH_DIV(DIV)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int n_cmp = 0;
  int n_err = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [6:0] dec(input int d);
    case (d)
      0: return 7'b1000000;
      1: return 7'b1111001;
      2: return 7'b0100100;
      3: return 7'b0110000;
      4: return 7'b0011001;
      5: return 7'b0010010;
      6: return 7'b0000010;
      7: return 7'b1111000;
      8: return 7'b0000000;
      9: return 7'b0010000;
      default: return 7'b1111111;
    endcase
  endfunction

  // Reference model: countdown of busy cycles, integer display value, scan by tick count
  bit         m_valid = 1'b0;
  int         m_snap, m_conv, m_rem, m_disp, m_tick, m_slot;
  int         m_h, m_t, m_u;
  bit         m_bh, m_bt;
  logic [3:0] m_an;
  logic [6:0] m_seg;
  logic       m_busy;

  always @(posedge clk) begin
    if (rst) begin
      m_valid = 1'b1;
      m_snap = 0; m_conv = 0; m_rem = 0; m_disp = 0; m_tick = 0; m_slot = 0;
      m_an = 4'b1111; m_seg = 7'b1111111; m_busy = 1'b0;
    end else if (m_valid) begin
      m_h = m_disp / 100;
      m_t = (m_disp / 10) % 10;
      m_u = m_disp % 10;
`ifdef LEADING_ZERO_BLANK_EN
      m_bh = (m_h == 0);
      m_bt = m_bh && (m_t == 0);
`else
      m_bh = 1'b0;
      m_bt = 1'b0;
`endif
      case (m_slot)
        0: begin m_an = 4'b1110; m_seg = dec(m_u); end
        1: begin m_an = 4'b1101; m_seg = m_bt ? 7'b1111111 : dec(m_t); end
        2: begin m_an = 4'b1011; m_seg = m_bh ? 7'b1111111 : dec(m_h); end
        default: begin m_an = 4'b1111; m_seg = 7'b1111111; end
      endcase
      if (m_rem == 0) begin
        if (int'(bus.count_in) != m_snap) begin
          m_snap = int'(bus.count_in);
          m_conv = m_snap;
          m_rem  = 9;
          m_busy = 1'b1;
        end
      end else begin
        m_rem = m_rem - 1;
        if (m_rem == 0) begin
          m_disp = m_conv;
          m_busy = 1'b0;
        end
      end
      if (m_tick == DIV - 1) begin
        m_tick = 0;
        m_slot = (m_slot + 1) % 4;
      end else begin
        m_tick = m_tick + 1;
      end
    end
  end

  always @(negedge clk) begin
    if (m_valid) begin
      chk("model_an", bus.an, m_an);
      chk("model_seg", bus.seg, m_seg);
      chk("model_busy", bus.busy, m_busy);
    end
  end

  task automatic wait_rise();
    int n;
    n = 0;
    while (bus.busy !== 1'b1 && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk("busy_rise", bus.busy, 1'b1);
  endtask

  // Counts busy-high cycles from the current negedge; optionally changes count_in on a given cycle
  task automatic busy_run(input int change_at, input logic [7:0] new_val, output int len);
    len = 0;
    while (bus.busy === 1'b1 && len < 50) begin
      len++;
      if (len == change_at) bus.count_in = new_val;
      @(negedge clk);
    end
  endtask

  task automatic set_count(input logic [7:0] v);
    @(posedge clk);
    #1;
    bus.count_in = v;
    $display("drive count_in=%0d", v);
  endtask

  task automatic check_frame(input string tag, input logic [6:0] eu, input logic [6:0] et,
                             input logic [6:0] eh);
    logic [6:0] su, st, sh, s3;
    bit seen3;
    su = 7'h00; st = 7'h00; sh = 7'h00; s3 = 7'h00; seen3 = 1'b0;
    repeat (4 * DIV + 2) begin
      @(negedge clk);
      case (bus.an)
        4'b1110: su = bus.seg;
        4'b1101: st = bus.seg;
        4'b1011: sh = bus.seg;
        4'b1111: begin s3 = bus.seg; seen3 = 1'b1; end
        default: ;
      endcase
    end
    chk({tag, "_units"}, su, eu);
    chk({tag, "_tens"}, st, et);
    chk({tag, "_hund"}, sh, eh);
    chk({tag, "_slot3"}, {seen3, s3}, {1'b1, 7'b1111111});
    $display("frame %s: u=%b t=%b h=%b", tag, su, st, sh);
  endtask

  int len1, gap, len2;
  logic [6:0] lz;

  initial begin
`ifdef LEADING_ZERO_BLANK_EN
    lz = 7'b1111111;
`else
    lz = 7'b1000000;
`endif
    rst = 1'b1;
    bus.count_in = 8'd0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_an", bus.an, 4'b1111);
    chk("reset_seg", bus.seg, 7'b1111111);
    chk("reset_busy", bus.busy, 1'b0);
    $display("reset held 3 cycles");

    // Test 1: release with count 0
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("first_slot0_an", bus.an, 4'b1110);
    chk("first_slot0_seg", bus.seg, 7'b1000000);
    check_frame("zero", 7'b1000000, lz, lz);
    chk("zero_no_busy", bus.busy, 1'b0);

    // Test 2: 137
    set_count(8'd137);
    wait_rise();
    busy_run(0, 8'd0, len1);
    chk("busy_len_137", len1, 9);
    check_frame("v137", 7'b1111000, 7'b0110000, 7'b1111001);

    // Test 3: 255 then 0
    set_count(8'd255);
    wait_rise();
    busy_run(0, 8'd0, len1);
    chk("busy_len_255", len1, 9);
    check_frame("v255", 7'b0010010, 7'b0010010, 7'b0100100);
    set_count(8'd0);
    wait_rise();
    busy_run(0, 8'd0, len1);
    check_frame("v000", 7'b1000000, lz, lz);

    // Test 4: 100, changed to 42 on the 3rd busy cycle
    set_count(8'd100);
    wait_rise();
    busy_run(3, 8'd42, len1);
    gap = 0;
    while (bus.busy !== 1'b1 && gap < 50) begin
      gap++;
      @(negedge clk);
    end
    busy_run(0, 8'd0, len2);
    chk("busy_len_100", len1, 9);
    chk("idle_gap", gap, 1);
    chk("busy_len_42", len2, 9);
    $display("back-to-back: busy %0d, idle %0d, busy %0d", len1, gap, len2);
    check_frame("v042", 7'b0010000 ^ 7'b0010000 ^ 7'b0100100, 7'b0011001, lz);

    // Test 5: 7 (leading-zero behaviour)
    set_count(8'd7);
    wait_rise();
    busy_run(0, 8'd0, len1);
    check_frame("v007", 7'b1111000, lz, lz);

    // Test 6: reset on the 5th busy cycle of 200
    set_count(8'd200);
    wait_rise();
    repeat (4) @(negedge clk);
    chk("busy_before_rst", bus.busy, 1'b1);
    rst = 1'b1;
    $display("reset asserted mid-conversion");
    @(negedge clk);
    chk("rst_mid_busy", bus.busy, 1'b0);
    chk("rst_mid_an", bus.an, 4'b1111);
    rst = 1'b0;
    @(negedge clk);
    chk("post_rst_an", bus.an, 4'b1110);
    chk("post_rst_seg", bus.seg, 7'b1000000);
    wait_rise();
    busy_run(0, 8'd0, len1);
    chk("busy_len_200", len1, 9);
    check_frame("v200", 7'b1000000, 7'b1000000, 7'b0100100);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
